// File: rtl/garage_door_pkg.sv
// garage_door_pkg: door state encodings and default plant geometry shared by the plant and the controller bench
package garage_door_pkg;
    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        HALTED  = 3'd4,
        FAULT   = 3'd5
    } door_state_t;
    localparam int DEF_TRAVEL_STEPS = 16;
    localparam int DEF_STEP_DIV = 8;
endpackage

// File: rtl/garage_door_if.sv
// garage_door_if: motor commands UP_motor/DN_motor in, limit switches UP_MAX/DN_MAX, pos, door_state, overrun, fault out of the plant
interface garage_door_if #(parameter int TRAVEL_STEPS = garage_door_pkg::DEF_TRAVEL_STEPS);
    import garage_door_pkg::*;
    localparam int POS_W = $clog2(TRAVEL_STEPS + 1);
    logic UP_motor;
    logic DN_motor;
    logic UP_MAX;
    logic DN_MAX;
    logic overrun;
    logic fault;
    logic [POS_W-1:0] pos;
    door_state_t door_state;
    modport master (output UP_motor, DN_motor, input UP_MAX, DN_MAX, pos, door_state, overrun, fault);
    modport slave (input UP_motor, DN_motor, output UP_MAX, DN_MAX, pos, door_state, overrun, fault);
endinterface

// File: rtl/door_step_timer.sv
// door_step_timer: STEP_DIV prescaler; clk/rst, run (count this cycle), clr (restart count from this cycle), step (one-cycle pulse on every STEP_DIV-th run cycle)
module door_step_timer #(
    parameter int STEP_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic step
);
    localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
    logic [CW-1:0] cnt;
    logic [CW-1:0] base;
    always_comb begin
        base = clr ? '0 : cnt;
        step = run & (base == LAST);
    end
    always_ff @(posedge clk)
        cnt <= (rst | ~run | step) ? '0 : base + 1'b1;
endmodule

// File: rtl/garage_door_plant.sv
// garage_door_plant: door position model; clk/rst, bus.slave takes UP_motor/DN_motor and returns UP_MAX, DN_MAX, pos, door_state, sticky overrun/fault
module garage_door_plant
    import garage_door_pkg::*;
#(
    parameter int TRAVEL_STEPS = DEF_TRAVEL_STEPS,
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input logic clk,
    input logic rst,
    garage_door_if.slave bus
);
    localparam int POS_W = $clog2(TRAVEL_STEPS + 1);
    localparam logic [POS_W-1:0] MAX = POS_W'(TRAVEL_STEPS);
    logic up, dn, both, at_max, at_min, run, clr, step, dir;
    logic [POS_W-1:0] pos_nxt;
    door_state_t state_nxt;
    always_comb begin
        up = bus.UP_motor & ~bus.DN_motor;
        dn = bus.DN_motor & ~bus.UP_motor;
        both = bus.UP_motor & bus.DN_motor;
        at_max = bus.pos == MAX;
        at_min = bus.pos == '0;
        run = (up & ~at_max) | (dn & ~at_min);
        clr = (up & ~dir) | (dn & dir);
    end
    door_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .clk(clk),
        .rst(rst),
        .run(run),
        .clr(clr),
        .step(step)
    );
    always_comb begin
        pos_nxt = ~step ? bus.pos : up ? bus.pos + 1'b1 : bus.pos - 1'b1;
        state_nxt = both ? FAULT :
                    (pos_nxt == '0 & ~up) ? CLOSED :
                    (pos_nxt == MAX & ~dn) ? OPEN :
                    up ? OPENING :
                    dn ? CLOSING : HALTED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pos <= '0;
            bus.UP_MAX <= 1'b0;
            bus.DN_MAX <= 1'b1;
            bus.door_state <= CLOSED;
            bus.overrun <= 1'b0;
            bus.fault <= 1'b0;
            dir <= 1'b0;
        end else begin
            bus.pos <= pos_nxt;
            bus.UP_MAX <= pos_nxt == MAX;
            bus.DN_MAX <= pos_nxt == '0;
            bus.door_state <= state_nxt;
            bus.overrun <= bus.overrun | (up & at_max) | (dn & at_min);
            bus.fault <= bus.fault | both;
            if (up | dn)
                dir <= up;
        end
    end
endmodule

// File: tb/tb_garage_door_plant.sv
// tb_garage_door_plant: directed scenarios plus randomized drive checked against a cycle-level behavioural door model
module tb_garage_door_plant;
    import garage_door_pkg::*;
    localparam int T = 8;
    localparam int S = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int m_pos, m_prog, m_dir, m_state;
    bit m_ovr, m_flt;
    garage_door_if #(.TRAVEL_STEPS(T)) bus();
    garage_door_plant #(.TRAVEL_STEPS(T), .STEP_DIV(S)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic void model_step(bit r, bit u, bit d);
        int dd;
        dd = (u && !d) ? 1 : (d && !u) ? -1 : 0;
        if (r) begin
            m_pos = 0; m_prog = 0; m_dir = 0; m_ovr = 0; m_flt = 0; m_state = 0;
            return;
        end
        if (u && d) begin
            m_flt = 1; m_prog = 0; m_state = 5;
            return;
        end
        if (dd == 0)
            m_prog = 0;
        else if ((dd > 0 && m_pos == T) || (dd < 0 && m_pos == 0)) begin
            m_ovr = 1; m_prog = 0;
        end else begin
            if (dd != m_dir) m_prog = 0;
            m_prog++;
            if (m_prog == S) begin
                m_pos += dd; m_prog = 0;
            end
        end
        if (dd != 0) m_dir = dd;
        if (dd == 0) m_state = m_pos == 0 ? 0 : m_pos == T ? 2 : 4;
        else if (dd > 0) m_state = m_pos == T ? 2 : 1;
        else m_state = m_pos == 0 ? 0 : 3;
    endfunction

    task automatic cycle(input bit r, input bit u, input bit d);
        rst = r; bus.UP_motor = u; bus.DN_motor = d;
        @(posedge clk);
        model_step(r, u, d);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0);
        checks++; if (bus.pos !== 0) begin errors++; $display("FAIL reset_pos: got %0d want 0", bus.pos); end
        checks++; if (bus.DN_MAX !== 1'b1) begin errors++; $display("FAIL reset_dn_max: got %b want 1", bus.DN_MAX); end
        checks++; if (bus.UP_MAX !== 1'b0) begin errors++; $display("FAIL reset_up_max: got %b want 0", bus.UP_MAX); end
        checks++; if (bus.door_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.door_state); end
        checks++; if ({bus.overrun, bus.fault} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b want 00", bus.overrun, bus.fault); end
    endtask

    task automatic test_full_open();
        cycle(1, 0, 0);
        for (int i = 1; i <= T * S; i++) begin
            cycle(0, 1, 0);
            if (i == S - 1) begin
                checks++; if (bus.pos !== 0 || bus.DN_MAX !== 1'b1) begin errors++; $display("FAIL open_pre_step: got pos=%0d dn_max=%b want pos=0 dn_max=1", bus.pos, bus.DN_MAX); end
            end
            if (i == S) begin
                checks++; if (bus.pos !== 1 || bus.DN_MAX !== 1'b0) begin errors++; $display("FAIL open_first_step: got pos=%0d dn_max=%b want pos=1 dn_max=0", bus.pos, bus.DN_MAX); end
                checks++; if (bus.door_state !== 3'd1) begin errors++; $display("FAIL open_opening: got %0d want 1", bus.door_state); end
            end
            if (i == T * S - 1) begin
                checks++; if (bus.pos !== T - 1 || bus.UP_MAX !== 1'b0) begin errors++; $display("FAIL open_pre_max: got pos=%0d up_max=%b want pos=%0d up_max=0", bus.pos, bus.UP_MAX, T - 1); end
            end
        end
        checks++; if (bus.pos !== T || bus.UP_MAX !== 1'b1) begin errors++; $display("FAIL open_full: got pos=%0d up_max=%b want pos=%0d up_max=1", bus.pos, bus.UP_MAX, T); end
        checks++; if (bus.door_state !== 3'd2) begin errors++; $display("FAIL open_state: got %0d want 2", bus.door_state); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0);
            checks++; if (bus.pos !== T) begin errors++; $display("FAIL overrun_pos: got %0d want %0d", bus.pos, T); end
            checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", bus.overrun); end
        end
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
        checks++; if (bus.door_state !== 3'd2 || bus.pos !== T) begin errors++; $display("FAIL overrun_rest: got state=%0d pos=%0d want state=2 pos=%0d", bus.door_state, bus.pos, T); end
    endtask

    task automatic test_stop_reverse();
        cycle(1, 0, 0);
        repeat (10) cycle(0, 1, 0);
        cycle(0, 0, 0);
        checks++; if (bus.pos !== 2 || bus.door_state !== 3'd4) begin errors++; $display("FAIL stop_halted: got pos=%0d state=%0d want pos=2 state=4", bus.pos, bus.door_state); end
        for (int i = 1; i <= 2 * S; i++) begin
            cycle(0, 0, 1);
            if (i == S - 1) begin
                checks++; if (bus.pos !== 2 || bus.door_state !== 3'd3) begin errors++; $display("FAIL rev_partial: got pos=%0d state=%0d want pos=2 state=3", bus.pos, bus.door_state); end
            end
            if (i == S) begin
                checks++; if (bus.pos !== 1) begin errors++; $display("FAIL rev_step1: got %0d want 1", bus.pos); end
            end
        end
        checks++; if (bus.pos !== 0 || bus.DN_MAX !== 1'b1 || bus.door_state !== 3'd0) begin errors++; $display("FAIL rev_closed: got pos=%0d dn_max=%b state=%0d want 0 1 0", bus.pos, bus.DN_MAX, bus.door_state); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rev_no_overrun: got %b want 0", bus.overrun); end
    endtask

    task automatic test_fault();
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        checks++; if (bus.overrun !== 1'b1 || bus.pos !== 0) begin errors++; $display("FAIL closed_overrun: got ovr=%b pos=%0d want 1 0", bus.overrun, bus.pos); end
        repeat (3 * S) cycle(0, 1, 0);
        checks++; if (bus.pos !== 3 || bus.door_state !== 3'd1) begin errors++; $display("FAIL fault_setup: got pos=%0d state=%0d want 3 1", bus.pos, bus.door_state); end
        repeat (5) cycle(0, 1, 1);
        checks++; if (bus.door_state !== 3'd5 || bus.pos !== 3) begin errors++; $display("FAIL fault_state: got state=%0d pos=%0d want 5 3", bus.door_state, bus.pos); end
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b want 1", bus.fault); end
        cycle(0, 0, 0);
        checks++; if (bus.door_state !== 3'd4 || bus.fault !== 1'b1) begin errors++; $display("FAIL fault_exit: got state=%0d fault=%b want 4 1", bus.door_state, bus.fault); end
    endtask

    task automatic test_reset_mid();
        repeat (2 * S + 2) cycle(0, 1, 0);
        checks++; if (bus.pos !== 5) begin errors++; $display("FAIL mid_setup: got %0d want 5", bus.pos); end
        cycle(1, 1, 0);
        checks++; if (bus.pos !== 0 || bus.DN_MAX !== 1'b1 || bus.UP_MAX !== 1'b0) begin errors++; $display("FAIL mid_reset_pos: got pos=%0d dn=%b up=%b want 0 1 0", bus.pos, bus.DN_MAX, bus.UP_MAX); end
        checks++; if ({bus.overrun, bus.fault} !== 2'b00 || bus.door_state !== 3'd0) begin errors++; $display("FAIL mid_reset_flags: got ovr=%b flt=%b state=%0d want 0 0 0", bus.overrun, bus.fault, bus.door_state); end
        for (int i = 1; i <= S; i++) begin
            cycle(0, 1, 0);
            if (i == S - 1) begin
                checks++; if (bus.pos !== 0) begin errors++; $display("FAIL mid_cnt_cleared: got %0d want 0", bus.pos); end
            end
        end
        checks++; if (bus.pos !== 1) begin errors++; $display("FAIL mid_resume: got %0d want 1", bus.pos); end
    endtask

    task automatic test_random();
        bit r, u, d;
        u = 0; d = 0;
        cycle(1, 0, 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) begin
                u = 1'($urandom_range(1));
                d = 1'($urandom_range(1));
            end
            r = $urandom_range(199) == 0;
            cycle(r, u, d);
            checks++; if (bus.pos !== m_pos) begin errors++; $display("FAIL rand_pos[%0d]: got %0d want %0d", i, bus.pos, m_pos); end
            checks++; if (bus.door_state !== 3'(m_state)) begin errors++; $display("FAIL rand_state[%0d]: got %0d want %0d", i, bus.door_state, m_state); end
            checks++; if (bus.UP_MAX !== (m_pos == T) || bus.DN_MAX !== (m_pos == 0)) begin errors++; $display("FAIL rand_limits[%0d]: got up=%b dn=%b for pos %0d", i, bus.UP_MAX, bus.DN_MAX, m_pos); end
            checks++; if (bus.overrun !== m_ovr || bus.fault !== m_flt) begin errors++; $display("FAIL rand_flags[%0d]: got ovr=%b flt=%b want %b %b", i, bus.overrun, bus.fault, m_ovr, m_flt); end
        end
    endtask

    initial begin
        bus.UP_motor = 1'b0;
        bus.DN_motor = 1'b0;
        test_reset();
        test_full_open();
        test_overrun();
        test_stop_reverse();
        test_fault();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
